// File: rtl/facto_pkg.sv
// Shared constants for the factorial accelerator: register offsets, FSM states, status bits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package facto_pkg;

  // Register offsets from the block base address
  localparam logic [15:0] OFF_OPSTART  = 16'h0000;
  localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
  localparam logic [15:0] OFF_OPDONE   = 16'h0010;
  localparam logic [15:0] OFF_INTREN   = 16'h0018;
  localparam logic [15:0] OFF_OPERAND  = 16'h0020;
  localparam logic [15:0] OFF_RESULT_H = 16'h0028;
  localparam logic [15:0] OFF_RESULT_L = 16'h0030;

  // Control FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_DEC  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Bit positions inside the opdone status register
  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

endpackage

// File: rtl/facto_mul_iter.sv
// Iterative 128x64 shift-add multiplier, product truncated to 128 bits.
// Latency: start sampled on one edge, done pulses 64 edges later; product holds until next start.
// Backpressure: none; a new start simply restarts it (also used to abandon a run). FACTO_OVF_FLAG_EN adds an overflow output.
module facto_mul_iter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] multiplicand,
  input  logic [63:0]  multiplier,
  output logic         done,
  output logic [127:0] product
`ifdef FACTO_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  logic [127:0] mcand;
  logic [63:0]  mplier;
  logic [5:0]   cnt;
  logic         running;

`ifdef FACTO_OVF_FLAG_EN
  // lost: a set bit of the multiplicand has been shifted past bit 127, so any
  // later partial product would itself be >= 2^128.
  logic         lost;
  logic [128:0] sum;
  assign sum = {1'b0, product} + {1'b0, mcand};
`endif

  // One multiplier bit per cycle, LSB first; done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef FACTO_OVF_FLAG_EN
      ovf     <= 1'b0;
      lost    <= 1'b0;
`endif
    end else if (start) begin
      mcand   <= multiplicand;
      mplier  <= multiplier;
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
      product <= '0;
`ifdef FACTO_OVF_FLAG_EN
      ovf     <= 1'b0;
      lost    <= 1'b0;
`endif
    end else if (running) begin
      if (mplier[0]) product <= product + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + 6'd1;
      running <= (cnt != 6'd63);
      done    <= (cnt == 6'd63);
`ifdef FACTO_OVF_FLAG_EN
      if (mplier[0] && (sum[128] || lost)) ovf <= 1'b1;
      if (mcand[127]) lost <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/facto_core.sv
// Memory-mapped factorial accelerator: operand! into a 128-bit result, level interrupt on completion.
// Latency: done 2 cycles after start for operand <= 1, else 66*(operand-1)+2 cycles; reads are combinational.
// Backpressure: none; bus accesses always complete, operand/intrEn writes dropped while busy. FACTO_OVF_FLAG_EN adds sticky opdone[2].
module facto_core
  import facto_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h7000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam logic [ADDR_W-1:0] A_OPSTART  = BASE_ADDR + ADDR_W'(OFF_OPSTART);
  localparam logic [ADDR_W-1:0] A_OPCLEAR  = BASE_ADDR + ADDR_W'(OFF_OPCLEAR);
  localparam logic [ADDR_W-1:0] A_OPDONE   = BASE_ADDR + ADDR_W'(OFF_OPDONE);
  localparam logic [ADDR_W-1:0] A_INTREN   = BASE_ADDR + ADDR_W'(OFF_INTREN);
  localparam logic [ADDR_W-1:0] A_OPERAND  = BASE_ADDR + ADDR_W'(OFF_OPERAND);
  localparam logic [ADDR_W-1:0] A_RESULT_H = BASE_ADDR + ADDR_W'(OFF_RESULT_H);
  localparam logic [ADDR_W-1:0] A_RESULT_L = BASE_ADDR + ADDR_W'(OFF_RESULT_L);

  logic [2:0]   state;
  logic         opstart;
  logic         intr_en;
  logic [63:0]  operand;
  logic [63:0]  n;
  logic [63:0]  n_dec;
  logic [127:0] result;
  logic [63:0]  status;
  logic         busy;
  logic         wr_en;
  logic         clear_req;
  logic         mul_start;
  logic         mul_done;
  logic [127:0] mul_mcand;
  logic [63:0]  mul_mplier;
  logic [127:0] mul_product;
`ifdef FACTO_OVF_FLAG_EN
  logic         mul_ovf;
  logic         ovf_flag;
`endif

  assign wr_en     = s_sel & s_wr;
  // opclear has no storage: it acts on the write edge and always reads back 0
  assign clear_req = wr_en && (s_addr == A_OPCLEAR) && s_din[0];
  assign busy      = (state == ST_INIT) || (state == ST_MUL) || (state == ST_DEC);
  assign interrupt = intr_en & status[STAT_DONE];

  // Launch the next multiply straight from the values being loaded this cycle
  always_comb begin
    n_dec      = n - 64'd1;
    mul_start  = 1'b0;
    mul_mcand  = mul_product;
    mul_mplier = n_dec;
    if (state == ST_INIT) begin
      mul_mcand  = 128'd1;
      mul_mplier = operand;
      mul_start  = (operand > 64'd1) && !clear_req;
    end else if (state == ST_DEC) begin
      mul_start  = (n_dec > 64'd1) && !clear_req;
    end
  end

  facto_mul_iter u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .multiplicand (mul_mcand),
    .multiplier   (mul_mplier),
    .done         (mul_done),
    .product      (mul_product)
`ifdef FACTO_OVF_FLAG_EN
    ,
    .ovf          (mul_ovf)
`endif
  );

  // Configuration registers; frozen while a computation is in flight, kept across opclear
  always_ff @(posedge clk) begin
    if (reset_n) begin
      operand <= '0;
      intr_en <= 1'b0;
    end else if (wr_en && !busy) begin
      if (s_addr == A_OPERAND) operand <= s_din;
      if (s_addr == A_INTREN)  intr_en <= s_din[0];
    end
  end

  // Control FSM and result; opclear beats any start and aborts a running multiply
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state   <= ST_IDLE;
      opstart <= 1'b0;
      n       <= '0;
      result  <= '0;
`ifdef FACTO_OVF_FLAG_EN
      ovf_flag <= 1'b0;
`endif
    end else if (clear_req) begin
      state   <= ST_IDLE;
      opstart <= 1'b0;
      result  <= '0;
`ifdef FACTO_OVF_FLAG_EN
      ovf_flag <= 1'b0;
`endif
    end else begin
      if (wr_en && (s_addr == A_OPSTART)) opstart <= s_din[0];
      case (state)
        ST_IDLE: if (opstart) state <= ST_INIT;
        ST_INIT: begin
          result <= 128'd1;
          n      <= operand;
          state  <= (operand > 64'd1) ? ST_MUL : ST_DONE;
        end
        ST_MUL:  if (mul_done) state <= ST_DEC;
        ST_DEC: begin
          result <= mul_product;
          n      <= n_dec;
          state  <= (n_dec > 64'd1) ? ST_MUL : ST_DONE;
`ifdef FACTO_OVF_FLAG_EN
          if (mul_ovf) ovf_flag <= 1'b1;
`endif
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Assemble the opdone status word
  always_comb begin
    status            = '0;
    status[STAT_DONE] = (state == ST_DONE);
    status[STAT_BUSY] = busy;
`ifdef FACTO_OVF_FLAG_EN
    status[STAT_OVF]  = ovf_flag;
`else
    status[STAT_OVF]  = 1'b0;
`endif
  end

  // Combinational read mux; unselected, writes and unmapped addresses return 0
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        A_OPSTART:  s_dout = {63'd0, opstart};
        A_OPDONE:   s_dout = status;
        A_INTREN:   s_dout = {63'd0, intr_en};
        A_OPERAND:  s_dout = operand;
        A_RESULT_H: s_dout = result[127:64];
        A_RESULT_L: s_dout = result[63:0];
        default:    s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_core.sv
// Self-checking bench for facto_core: register map, latency, clear/abort, reset, random operands.
// Latency: checks done against the per-operand cycle bound.
// Backpressure: n/a.
module tb_facto_core;

  localparam logic [15:0] A_START = 16'h7000;
  localparam logic [15:0] A_CLR   = 16'h7008;
  localparam logic [15:0] A_DONE  = 16'h7010;
  localparam logic [15:0] A_IEN   = 16'h7018;
  localparam logic [15:0] A_OPND  = 16'h7020;
  localparam logic [15:0] A_RESH  = 16'h7028;
  localparam logic [15:0] A_RESL  = 16'h7030;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_addr = '0;
  logic [63:0] s_din = '0;
  logic [63:0] s_dout;
  logic        interrupt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  facto_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  typedef struct {
    logic [63:0]  op;
    logic         ien;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[7];

  // Reference: factorial in plain 128-bit arithmetic (wraps naturally)
  function automatic logic [127:0] fact(input int unsigned k);
    logic [127:0] f;
    f = 128'd1;
    for (int unsigned i = 2; i <= k; i++) f = f * 128'(i);
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(negedge clk);
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  // Full operation: clear, configure, start, poll with the latency bound, check results
  task automatic run_op(input logic [63:0] op, input logic ien, input logic [127:0] exp, input string tag);
    logic [63:0] d;
    logic [63:0] rh;
    logic [63:0] rl;
    int bound;
    int bad;
    bit done;
    wr(A_CLR, 64'd1);
    wr(A_IEN, {63'd0, ien});
    wr(A_OPND, op);
    wr(A_START, 64'd1);
    bound = (op <= 64'd1) ? 2 : (int'(op) - 1) * 66 + 4;
    done = 1'b0;
    bad = 0;
    for (int k = 0; k <= bound; k++) begin
      rd(A_DONE, d);
      if (d == 64'd1) begin
        done = 1'b1;
        break;
      end
      if (k > 0 && d != 64'd2) bad++;
      @(negedge clk);
    end
    chk({tag, "_done_in_time"}, {127'd0, done}, 128'd1);
    chk({tag, "_busy_status_bad"}, 128'(bad), 128'd0);
    rd(A_RESH, rh);
    rd(A_RESL, rl);
    chk({tag, "_result"}, {rh, rl}, exp);
    chk({tag, "_interrupt"}, {127'd0, interrupt}, {127'd0, ien});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [63:0] op;
    logic        ien;

    tbl[0] = '{64'd7,  1'b1, 128'h13B0};
    tbl[1] = '{64'd0,  1'b1, 128'd1};
    tbl[2] = '{64'd1,  1'b0, 128'd1};
    tbl[3] = '{64'd20, 1'b0, 128'h21C3677C82B40000};
    tbl[4] = '{64'd5,  1'b1, 128'h78};
    tbl[5] = '{64'd2,  1'b1, 128'd2};
    tbl[6] = '{64'd3,  1'b0, 128'd6};

    // Reset: every register and interrupt reads 0
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    for (int a = 0; a <= 16'h38; a += 8) begin
      rd(16'h7000 + 16'(a), d);
      chk($sformatf("reset_read_%0h", a), d, 0);
    end
    chk("reset_interrupt", {127'd0, interrupt}, 0);

    // Table-driven operations
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].op, tbl[i].ien, tbl[i].exp, $sformatf("tbl%0d_op%0d", i, tbl[i].op));

    // Operand 0: exact two-cycle latency
    wr(A_CLR, 64'd1);
    wr(A_OPND, 64'd0);
    wr(A_START, 64'd1);
    rd(A_DONE, d); chk("op0_cycle0_status", d, 0);
    @(negedge clk);
    rd(A_DONE, d); chk("op0_cycle1_status", d, 2);
    @(negedge clk);
    rd(A_DONE, d); chk("op0_cycle2_status", d, 1);

    // Done with 7, then rewrite start (no restart) and clear
    run_op(64'd7, 1'b1, 128'h13B0, "clr_seq");
    rd(A_START, d); chk("opstart_held", d, 1);
    wr(A_START, 64'd1);
    repeat (3) @(negedge clk);
    rd(A_DONE, d); chk("rewrite_start_in_done", d, 1);
    rd(A_RESL, d); chk("rewrite_start_result", d, 64'h13B0);
    wr(A_CLR, 64'd1);
    chk("clear_interrupt", {127'd0, interrupt}, 0);
    rd(A_DONE, d); chk("clear_opdone", d, 0);
    rd(A_START, d); chk("clear_opstart", d, 0);
    rd(A_OPND, d); chk("clear_keeps_operand", d, 7);
    rd(A_IEN, d); chk("clear_keeps_intren", d, 1);
    rd(A_RESL, d); chk("clear_result_l", d, 0);
    rd(A_CLR, d); chk("opclear_reads_0", d, 0);
    repeat (10) @(negedge clk);
    rd(A_DONE, d); chk("no_retrigger_after_clear", d, 0);
    wr(A_START, 64'd1);
    rd(A_DONE, d); chk("restart_cycle0", d, 0);
    @(negedge clk);
    rd(A_DONE, d); chk("restart_busy", d, 2);

    // Abort mid-computation, writes ignored while busy, then operand 5
    wr(A_CLR, 64'd1);
    wr(A_IEN, 64'd0);
    wr(A_OPND, 64'd20);
    wr(A_START, 64'd1);
    repeat (100) @(negedge clk);
    wr(A_OPND, 64'd3);
    rd(A_OPND, d); chk("operand_locked_busy", d, 20);
    wr(A_IEN, 64'd1);
    rd(A_IEN, d); chk("intren_locked_busy", d, 0);
    wr(A_CLR, 64'd1);
    rd(A_DONE, d); chk("abort_opdone", d, 0);
    rd(A_RESH, d); chk("abort_result_h", d, 0);
    rd(A_RESL, d); chk("abort_result_l", d, 0);
    repeat (5) @(negedge clk);
    rd(A_DONE, d); chk("abort_stays_idle", d, 0);
    run_op(64'd5, 1'b0, 128'h78, "after_abort");

    // Reset in the middle of a multiply
    wr(A_CLR, 64'd1);
    wr(A_IEN, 64'd1);
    wr(A_OPND, 64'd20);
    wr(A_START, 64'd1);
    repeat (50) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    rd(A_DONE, d); chk("midreset_opdone", d, 0);
    rd(A_OPND, d); chk("midreset_operand", d, 0);
    rd(A_IEN, d); chk("midreset_intren", d, 0);
    rd(A_START, d); chk("midreset_opstart", d, 0);
    repeat (80) @(negedge clk);
    rd(A_DONE, d); chk("midreset_no_late_done", d, 0);

    // Read-only / unmapped writes ignored, unmapped reads 0
    wr(A_RESL, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_RESL, d); chk("ro_result_l", d, 0);
    wr(A_DONE, 64'h7);
    rd(A_DONE, d); chk("ro_opdone", d, 0);
    wr(A_OPND, 64'h55);
    rd(16'h7021, d); chk("misaligned_read", d, 0);
    rd(16'h6020, d); chk("outside_base_read", d, 0);
    wr(16'h7038, 64'h1234);
    rd(16'h7038, d); chk("unmapped_read", d, 0);
    rd(A_OPND, d); chk("operand_rw", d, 64'h55);

    // Random operands against the reference model (includes 128-bit wrap)
    for (int i = 0; i < 6; i++) begin
      op = 64'($urandom_range(0, 40));
      ien = 1'($urandom_range(0, 1));
      run_op(op, ien, fact(int'(op)), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
